// File: rtl/alu_8bit.sv
// Registered 8-bit ALU: 4-bit opcode, result plus zero/negative/carry/overflow flags, one-cycle latency.
// Define ALU_ROTATE_EN to enable ROL (1101) and ROR (1110); otherwise 1101-1111 yield zero.
module alu_8bit (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [3:0] select_line,
    output logic [7:0] result,
    output logic       zero_flag,
    output logic       negative_flag,
    output logic       carry_flag,
    output logic       overflow_flag
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_NAND = 4'b0101;
    localparam logic [3:0] OP_NOR  = 4'b0110;
    localparam logic [3:0] OP_XNOR = 4'b0111;
    localparam logic [3:0] OP_NOT  = 4'b1000;
    localparam logic [3:0] OP_INC  = 4'b1001;
    localparam logic [3:0] OP_DEC  = 4'b1010;
    localparam logic [3:0] OP_SHL  = 4'b1011;
    localparam logic [3:0] OP_SHR  = 4'b1100;
`ifdef ALU_ROTATE_EN
    localparam logic [3:0] OP_ROL  = 4'b1101;
    localparam logic [3:0] OP_ROR  = 4'b1110;
`endif

    logic [8:0] sum;
    logic [8:0] diff;
    logic [7:0] next_result;
    logic       next_carry;
    logic       next_overflow;

    // Bit 8 of the widened difference is the unsigned borrow.
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        next_result   = 8'h00;
        next_carry    = 1'b0;
        next_overflow = 1'b0;
        case (select_line)
            OP_ADD: begin
                next_result   = sum[7:0];
                next_carry    = sum[8];
                next_overflow = (a[7] == b[7]) && (sum[7] != a[7]);
            end
            OP_SUB: begin
                next_result   = diff[7:0];
                next_carry    = diff[8];
                next_overflow = (a[7] != b[7]) && (diff[7] != a[7]);
            end
            OP_AND:  next_result = a & b;
            OP_OR:   next_result = a | b;
            OP_XOR:  next_result = a ^ b;
            OP_NAND: next_result = ~(a & b);
            OP_NOR:  next_result = ~(a | b);
            OP_XNOR: next_result = ~(a ^ b);
            OP_NOT:  next_result = ~a;
            OP_INC: begin
                next_result   = a + 8'h01;
                next_carry    = (a == 8'hFF);
                next_overflow = (a == 8'h7F);
            end
            OP_DEC: begin
                next_result   = a - 8'h01;
                next_carry    = (a == 8'h00);
                next_overflow = (a == 8'h80);
            end
            OP_SHL: begin
                next_result = {a[6:0], 1'b0};
                next_carry  = a[7];
            end
            OP_SHR: begin
                next_result = {1'b0, a[7:1]};
                next_carry  = a[0];
            end
`ifdef ALU_ROTATE_EN
            OP_ROL: begin
                next_result = {a[6:0], a[7]};
                next_carry  = a[7];
            end
            OP_ROR: begin
                next_result = {a[0], a[7:1]};
                next_carry  = a[0];
            end
`endif
            default: ;
        endcase
    end

    // Reset clears every output, including zero_flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            result        <= 8'h00;
            zero_flag     <= 1'b0;
            negative_flag <= 1'b0;
            carry_flag    <= 1'b0;
            overflow_flag <= 1'b0;
        end else begin
            result        <= next_result;
            zero_flag     <= (next_result == 8'h00);
            negative_flag <= next_result[7];
            carry_flag    <= next_carry;
            overflow_flag <= next_overflow;
        end
    end

endmodule

// File: tb/tb_alu_8bit.sv
// Directed self-checking bench for alu_8bit; expectations are hand-computed vectors.
// Rotate expectations follow ALU_ROTATE_EN when the bench is built with it.
module tb_alu_8bit;

    logic       clk;
    logic       rst;
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] select_line;
    logic [7:0] result;
    logic       zero_flag;
    logic       negative_flag;
    logic       carry_flag;
    logic       overflow_flag;

    int checks;
    int errors;

    alu_8bit dut (
        .clk           (clk),
        .rst           (rst),
        .a             (a),
        .b             (b),
        .select_line   (select_line),
        .result        (result),
        .zero_flag     (zero_flag),
        .negative_flag (negative_flag),
        .carry_flag    (carry_flag),
        .overflow_flag (overflow_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive operands, then let one edge capture them and sample 1 ns later.
    task automatic apply_stimulus(input logic [7:0] av, input logic [7:0] bv, input logic [3:0] op);
        a           = av;
        b           = bv;
        select_line = op;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [11:0] got;
        rst = 1'b1;
        apply_stimulus(8'hCA, 8'h67, 4'b0000);
        got = {result, zero_flag, negative_flag, carry_flag, overflow_flag};
        checks++;
        if (got !== 12'h000) begin
            errors++;
            $display("[TB] FAIL reset_init got=%h want=%h", got, 12'h000);
        end
        rst = 1'b0;
        apply_stimulus(8'h7F, 8'h01, 4'b0000);
        // ADD with rst asserted on the same edge must never surface.
        rst = 1'b1;
        apply_stimulus(8'hCA, 8'h67, 4'b0000);
        got = {result, zero_flag, negative_flag, carry_flag, overflow_flag};
        checks++;
        if (got !== 12'h000) begin
            errors++;
            $display("[TB] FAIL reset_override got=%h want=%h", got, 12'h000);
        end
        rst = 1'b0;
        apply_stimulus(8'hCA, 8'h67, 4'b0000);
        got = {result, zero_flag, negative_flag, carry_flag, overflow_flag};
        checks++;
        if (got !== {8'h31, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset_release got=%h want=%h", got, {8'h31, 4'b0010});
        end
    endtask

    task automatic test_sweep();
        logic [9:0]  tab [13];
        logic [11:0] got;
        logic [11:0] want;
        // Entries: {result, carry, overflow} for a=CA b=67, opcodes 0..12.
        tab = '{{8'h31, 2'b10}, {8'h63, 2'b01}, {8'h42, 2'b00}, {8'hEF, 2'b00},
                {8'hAD, 2'b00}, {8'hBD, 2'b00}, {8'h10, 2'b00}, {8'h52, 2'b00},
                {8'h35, 2'b00}, {8'hCB, 2'b00}, {8'hC9, 2'b00}, {8'h94, 2'b10},
                {8'h65, 2'b00}};
        for (int i = 0; i < 13; i++) begin
            apply_stimulus(8'hCA, 8'h67, 4'(i));
            got  = {result, zero_flag, negative_flag, carry_flag, overflow_flag};
            want = {tab[i][9:2], tab[i][9:2] == 8'h00, tab[i][9], tab[i][1:0]};
            checks++;
            if (got !== want) begin
                errors++;
                $display("[TB] FAIL sweep op=%0d got=%h want=%h", i, got, want);
            end
        end
    endtask

    task automatic test_edge_arith();
        logic [29:0] tab [8];
        logic [11:0] got;
        logic [11:0] want;
        // Entries: {a, b, op, result, carry, overflow}.
        tab = '{{8'hFF, 8'h01, 4'b0000, 8'h00, 2'b10},
                {8'h7F, 8'h01, 4'b0000, 8'h80, 2'b01},
                {8'h05, 8'h05, 4'b0001, 8'h00, 2'b00},
                {8'h00, 8'h01, 4'b0001, 8'hFF, 2'b10},
                {8'hFF, 8'h33, 4'b1001, 8'h00, 2'b10},
                {8'h7F, 8'h33, 4'b1001, 8'h80, 2'b01},
                {8'h00, 8'h33, 4'b1010, 8'hFF, 2'b10},
                {8'h80, 8'h33, 4'b1010, 8'h7F, 2'b01}};
        for (int i = 0; i < 8; i++) begin
            apply_stimulus(tab[i][29:22], tab[i][21:14], tab[i][13:10]);
            got  = {result, zero_flag, negative_flag, carry_flag, overflow_flag};
            want = {tab[i][9:2], tab[i][9:2] == 8'h00, tab[i][9], tab[i][1:0]};
            checks++;
            if (got !== want) begin
                errors++;
                $display("[TB] FAIL edge_arith idx=%0d got=%h want=%h", i, got, want);
            end
        end
    endtask

    task automatic test_undefined();
        logic [11:0] got;
        logic [11:0] want;
        apply_stimulus(8'hCA, 8'h67, 4'b1111);
        got = {result, zero_flag, negative_flag, carry_flag, overflow_flag};
        checks++;
        if (got !== {8'h00, 4'b1000}) begin
            errors++;
            $display("[TB] FAIL undef_1111 got=%h want=%h", got, {8'h00, 4'b1000});
        end
`ifdef ALU_ROTATE_EN
        want = {8'h95, 4'b0110};
`else
        want = {8'h00, 4'b1000};
`endif
        apply_stimulus(8'hCA, 8'h67, 4'b1101);
        got = {result, zero_flag, negative_flag, carry_flag, overflow_flag};
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL op_1101 got=%h want=%h", got, want);
        end
`ifdef ALU_ROTATE_EN
        want = {8'h65, 4'b0000};
`else
        want = {8'h00, 4'b1000};
`endif
        apply_stimulus(8'hCA, 8'h67, 4'b1110);
        got = {result, zero_flag, negative_flag, carry_flag, overflow_flag};
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL op_1110 got=%h want=%h", got, want);
        end
    endtask

    task automatic test_back_to_back();
        logic [25:0] tab [16];
        logic [11:0] got;
        logic [11:0] want;
        // Entries: {a, b, result, carry, overflow}; opcode equals the index.
        tab = '{{8'h10, 8'h20, 8'h30, 2'b00},
                {8'h80, 8'h01, 8'h7F, 2'b01},
                {8'hF0, 8'h3C, 8'h30, 2'b00},
                {8'h0F, 8'h30, 8'h3F, 2'b00},
                {8'hFF, 8'h0F, 8'hF0, 2'b00},
                {8'hFF, 8'hFF, 8'h00, 2'b00},
                {8'h00, 8'h00, 8'hFF, 2'b00},
                {8'hAA, 8'h55, 8'h00, 2'b00},
                {8'h0F, 8'h12, 8'hF0, 2'b00},
                {8'h01, 8'h12, 8'h02, 2'b00},
                {8'h01, 8'h12, 8'h00, 2'b00},
                {8'h81, 8'h12, 8'h02, 2'b10},
                {8'h81, 8'h12, 8'h40, 2'b10},
`ifdef ALU_ROTATE_EN
                {8'hCA, 8'h12, 8'h95, 2'b10},
                {8'hCA, 8'h12, 8'h65, 2'b00},
`else
                {8'hCA, 8'h12, 8'h00, 2'b00},
                {8'hCA, 8'h12, 8'h00, 2'b00},
`endif
                {8'hCA, 8'h12, 8'h00, 2'b00}};
        for (int i = 0; i < 16; i++) begin
            apply_stimulus(tab[i][25:18], tab[i][17:10], 4'(i));
            got  = {result, zero_flag, negative_flag, carry_flag, overflow_flag};
            want = {tab[i][9:2], tab[i][9:2] == 8'h00, tab[i][9], tab[i][1:0]};
            checks++;
            if (got !== want) begin
                errors++;
                $display("[TB] FAIL b2b cycle=%0d got=%h want=%h", i, got, want);
            end
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        a           = 8'h00;
        b           = 8'h00;
        select_line = 4'h0;
        test_reset();
        test_sweep();
        test_edge_arith();
        test_undefined();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
